// File: rtl/gpio_mult_pkg.sv
// Shared definitions for the GPIO multiplier bus initiator.
// Holds the default register map, the status bit positions and the state encodings.
// Contains no logic; latency and backpressure do not apply.
package gpio_mult_pkg;

  localparam logic [15:0] DEF_ADDR_A1   = 16'h037F;
  localparam logic [15:0] DEF_ADDR_A2   = 16'h0388;
  localparam logic [15:0] DEF_ADDR_W    = 16'h0390;
  localparam logic [15:0] DEF_ADDR_L    = 16'h0398;
  localparam logic [15:0] DEF_ADDR_CTRL = 16'h03A0;

  // Status register B: bit1 = product ready, bit0 = product fits in 32 bits
  localparam int READY_BIT = 1;
  localparam int VALID_BIT = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_A1,
    ST_WR_A2,
    ST_WR_GO,
    ST_WAIT,
    ST_RD_STAT,
    ST_RD_W,
    ST_RD_L,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    X_IDLE,
    X_SETUP,
    X_STB,
    X_HOLD
  } xfer_ph_t;

endpackage

// File: rtl/gpio_bus_xfer.sv
// Single read or write on the saddress/srd/swr/sdata bus with SETUP/STROBE/HOLD phases.
// Latency: SETUP_CYC + STB_CYC + 1 cycles after the start cycle; o_done is high during HOLD.
// No backpressure: i_start is only honoured while idle, so the caller waits for o_done.
module gpio_bus_xfer #(
  parameter int SETUP_CYC = 1,
  parameter int STB_CYC   = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        i_start,
  input  logic        i_rnw,
  input  logic [15:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [15:0] o_saddress,
  output logic        o_swr,
  output logic        o_srd,
  output logic [31:0] o_sdata_wr,
  input  logic [31:0] i_sdata_rd
);
  import gpio_mult_pkg::*;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STB_LAST   = 8'(STB_CYC - 1);

  xfer_ph_t   r_ph;
  logic [7:0] r_cnt;
  logic       r_rnw;

  // Phase sequencer; pins are registered so strobes drop asynchronously on reset
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_ph       <= X_IDLE;
      r_cnt      <= 8'd0;
      r_rnw      <= 1'b0;
      o_rdata    <= 32'd0;
      o_saddress <= 16'd0;
      o_swr      <= 1'b0;
      o_srd      <= 1'b0;
      o_sdata_wr <= 32'd0;
    end else begin
      case (r_ph)
        X_IDLE: begin
          if (i_start) begin
            o_saddress <= i_addr;
            o_sdata_wr <= i_rnw ? 32'd0 : i_wdata;
            r_rnw      <= i_rnw;
            r_cnt      <= 8'd0;
            r_ph       <= X_SETUP;
          end
        end
        X_SETUP: begin
          if (r_cnt == SETUP_LAST) begin
            r_cnt <= 8'd0;
            o_swr <= ~r_rnw;
            o_srd <= r_rnw;
            r_ph  <= X_STB;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        X_STB: begin
          if (r_cnt == STB_LAST) begin
            o_swr <= 1'b0;
            o_srd <= 1'b0;
            if (r_rnw) o_rdata <= i_sdata_rd;
            r_ph  <= X_HOLD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        X_HOLD: begin
          // Address and data stay put through HOLD and return to 0 after it
          o_saddress <= 16'd0;
          o_sdata_wr <= 32'd0;
          r_ph       <= X_IDLE;
        end
        default: r_ph <= X_IDLE;
      endcase
    end
  end

  assign o_done = (r_ph == X_HOLD);

endmodule

// File: rtl/gpio_mult_initiator.sv
// Bus-master sequencer: writes two operands and start, polls status, reads product and ones count.
// Latency: 5 bus transactions + START_WAIT + extra polls + 1 cycle from job accept to res_valid.
// One job in flight; job_ready low until the result is taken; result held while res_ready is low.
module gpio_mult_initiator #(
  parameter logic [15:0] ADDR_A1    = gpio_mult_pkg::DEF_ADDR_A1,
  parameter logic [15:0] ADDR_A2    = gpio_mult_pkg::DEF_ADDR_A2,
  parameter logic [15:0] ADDR_W     = gpio_mult_pkg::DEF_ADDR_W,
  parameter logic [15:0] ADDR_L     = gpio_mult_pkg::DEF_ADDR_L,
  parameter logic [15:0] ADDR_CTRL  = gpio_mult_pkg::DEF_ADDR_CTRL,
  parameter int          SETUP_CYC  = 1,
  parameter int          STB_CYC    = 2,
  parameter int          START_WAIT = 4,
  parameter int          POLL_MAX   = 64
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [23:0] job_a1,
  input  logic [23:0] job_a2,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_w,
  output logic [23:0] res_ones,
  output logic        res_ovf,
  output logic        res_timeout,
  output logic [15:0] m_saddress,
  output logic        m_swr,
  output logic        m_srd,
  output logic [31:0] m_sdata_wr,
  input  logic [31:0] m_sdata_rd,
  output logic [15:0] job_count
);
  import gpio_mult_pkg::*;

  localparam logic [15:0] POLL_LIM  = 16'(POLL_MAX);
  localparam logic [15:0] WAIT_LAST = 16'(START_WAIT - 1);

  state_t      r_state;
  logic        r_start;
  logic [23:0] r_a1, r_a2;
  logic [15:0] r_poll, r_wcnt;
  logic        r_job_ready, r_res_valid, r_res_ovf, r_res_timeout;
  logic [31:0] r_res_w;
  logic [23:0] r_res_ones;
  logic [15:0] r_job_count;

  logic        w_done, w_rnw;
  logic [15:0] w_addr;
  logic [31:0] w_wdata, w_rdata;

  // Transaction parameters follow the state that r_start has just entered
  always_comb begin
    w_addr  = 16'd0;
    w_wdata = 32'd0;
    w_rnw   = 1'b1;
    case (r_state)
      ST_WR_A1:   begin w_addr = ADDR_A1;   w_wdata = {8'h00, r_a1}; w_rnw = 1'b0; end
      ST_WR_A2:   begin w_addr = ADDR_A2;   w_wdata = {8'h00, r_a2}; w_rnw = 1'b0; end
      ST_WR_GO:   begin w_addr = ADDR_CTRL; w_rnw = 1'b0; end
      ST_RD_STAT: w_addr = ADDR_CTRL;
      ST_RD_W:    w_addr = ADDR_W;
      ST_RD_L:    w_addr = ADDR_L;
      default:    ;
    endcase
  end

  // Job sequencer: each bus state launches its transaction on entry and advances on done
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state       <= ST_IDLE;
      r_start       <= 1'b0;
      r_a1          <= 24'd0;
      r_a2          <= 24'd0;
      r_poll        <= 16'd0;
      r_wcnt        <= 16'd0;
      r_job_ready   <= 1'b1;
      r_res_valid   <= 1'b0;
      r_res_w       <= 32'd0;
      r_res_ones    <= 24'd0;
      r_res_ovf     <= 1'b0;
      r_res_timeout <= 1'b0;
      r_job_count   <= 16'd0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (job_valid && r_job_ready) begin
            r_a1          <= job_a1;
            r_a2          <= job_a2;
            r_job_ready   <= 1'b0;
            r_res_w       <= 32'd0;
            r_res_ones    <= 24'd0;
            r_res_ovf     <= 1'b0;
            r_res_timeout <= 1'b0;
            r_state       <= ST_WR_A1;
            r_start       <= 1'b1;
          end
        end
        ST_WR_A1: if (w_done) begin r_state <= ST_WR_A2; r_start <= 1'b1; end
        ST_WR_A2: if (w_done) begin r_state <= ST_WR_GO; r_start <= 1'b1; end
        ST_WR_GO: begin
          if (w_done) begin
            r_poll <= 16'd0;
            r_wcnt <= 16'd0;
            if (START_WAIT == 0) begin
              r_state <= ST_RD_STAT;
              r_start <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_wcnt == WAIT_LAST) begin
            r_state <= ST_RD_STAT;
            r_start <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + 16'd1;
          end
        end
        ST_RD_STAT: begin
          if (w_done) begin
            r_poll <= r_poll + 16'd1;
            if (w_rdata[READY_BIT]) begin
              r_res_ovf <= ~w_rdata[VALID_BIT];
              r_state   <= ST_RD_W;
              r_start   <= 1'b1;
            end else if (r_poll + 16'd1 == POLL_LIM) begin
              r_res_timeout <= 1'b1;
              r_res_w       <= 32'd0;
              r_res_ones    <= 24'd0;
              r_res_ovf     <= 1'b0;
              r_res_valid   <= 1'b1;
              r_state       <= ST_RESP;
            end else begin
              r_start <= 1'b1;
            end
          end
        end
        ST_RD_W: begin
          if (w_done) begin
            r_res_w <= w_rdata;
            r_state <= ST_RD_L;
            r_start <= 1'b1;
          end
        end
        ST_RD_L: begin
          if (w_done) begin
            r_res_ones  <= w_rdata[23:0];
            r_res_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_job_count <= r_job_count + 16'd1;
            r_job_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  gpio_bus_xfer #(
    .SETUP_CYC (SETUP_CYC),
    .STB_CYC   (STB_CYC)
  ) u_xfer (
    .clk        (clk),
    .n_reset    (n_reset),
    .i_start    (r_start),
    .i_rnw      (w_rnw),
    .i_addr     (w_addr),
    .i_wdata    (w_wdata),
    .o_done     (w_done),
    .o_rdata    (w_rdata),
    .o_saddress (m_saddress),
    .o_swr      (m_swr),
    .o_srd      (m_srd),
    .o_sdata_wr (m_sdata_wr),
    .i_sdata_rd (m_sdata_rd)
  );

  assign job_ready   = r_job_ready;
  assign res_valid   = r_res_valid;
  assign res_w       = r_res_w;
  assign res_ones    = r_res_ones;
  assign res_ovf     = r_res_ovf;
  assign res_timeout = r_res_timeout;
  assign job_count   = r_job_count;

endmodule

// File: tb/tb_gpio_mult_initiator.sv
// Bench for gpio_mult_initiator with a behavioural peripheral and a job-level expectation model.
// Runs directed jobs: basic, overflow, timeout, backpressure, reset mid-write, clean restart.
// Consumer backpressure is driven explicitly through res_ready.
module tb_gpio_mult_initiator;

  localparam int STB  = 2;
  localparam int PMAX = 4;
  localparam logic [15:0] A_A1 = 16'h037F;
  localparam logic [15:0] A_A2 = 16'h0388;
  localparam logic [15:0] A_W  = 16'h0390;
  localparam logic [15:0] A_L  = 16'h0398;
  localparam logic [15:0] A_C  = 16'h03A0;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk, n_reset;
  logic        job_valid, job_ready, res_valid, res_ready;
  logic [23:0] job_a1, job_a2, res_ones;
  logic [31:0] res_w, m_sdata_wr, m_sdata_rd;
  logic        res_ovf, res_timeout, m_swr, m_srd;
  logic [15:0] m_saddress, job_count;

  int checks = 0;
  int errors = 0;

  // peripheral configuration for the current job
  int          cfg_rdy;
  logic        cfg_b0;
  logic [31:0] cfg_w, cfg_l;
  int          stat_n;
  logic        sl_prev;

  // model expectations
  txn_t        trace[$];
  txn_t        exp_trace[$];
  logic [31:0] e_w;
  logic [23:0] e_ones;
  logic        e_ovf, e_to;
  logic [15:0] exp_cnt;

  // compare-process trackers
  logic        p_stb;
  logic [15:0] p_addr, s_addr;
  int          hi_len;

  // results captured at accept
  logic [31:0] last_w;
  logic [23:0] last_ones;
  logic        last_ovf, last_to;

  gpio_mult_initiator #(.POLL_MAX(PMAX)) dut (
    .clk(clk), .n_reset(n_reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_a1(job_a1), .job_a2(job_a2),
    .res_valid(res_valid), .res_ready(res_ready), .res_w(res_w), .res_ones(res_ones),
    .res_ovf(res_ovf), .res_timeout(res_timeout),
    .m_saddress(m_saddress), .m_swr(m_swr), .m_srd(m_srd),
    .m_sdata_wr(m_sdata_wr), .m_sdata_rd(m_sdata_rd), .job_count(job_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic wr, input logic [15:0] addr, input logic [31:0] data);
    txn_t t;
    t.wr = wr; t.addr = addr; t.data = data;
    return t;
  endfunction

  // peripheral: answers each read strobe from its register map; status upper bits are junk
  always @(negedge clk) begin
    if (m_srd && !sl_prev) begin
      if (m_saddress == A_C) begin
        stat_n++;
        m_sdata_rd = {30'h15555555, (cfg_rdy != 0 && stat_n >= cfg_rdy), cfg_b0};
      end else if (m_saddress == A_W) m_sdata_rd = cfg_w;
      else if (m_saddress == A_L)     m_sdata_rd = cfg_l;
      else                            m_sdata_rd = 32'hBAD0BAD0;
    end
    sl_prev = m_srd;
  end

  // compare process: counter, result record, strobe timing, bus trace capture
  always @(negedge clk) begin
    if (!n_reset) begin
      p_stb  = 1'b0;
      hi_len = 0;
      p_addr = 16'd0;
    end else begin
      chk("job_count", job_count, exp_cnt);
      if (res_valid)
        chk("result", {res_w, res_ones, res_ovf, res_timeout}, {e_w, e_ones, e_ovf, e_to});
      if (m_swr || m_srd) chk("one_strobe", m_swr & m_srd, 0);
      if ((m_swr || m_srd) && !p_stb) begin
        chk("setup_addr", m_saddress, p_addr);
        trace.push_back(mk(m_swr, m_saddress, m_swr ? m_sdata_wr : 32'h0));
        hi_len = 1;
        s_addr = m_saddress;
      end else if (m_swr || m_srd) begin
        hi_len++;
        chk("stb_addr", m_saddress, s_addr);
      end else if (p_stb) begin
        chk("stb_len", hi_len, STB);
        chk("hold_addr", m_saddress, s_addr);
      end
      p_stb  = m_swr | m_srd;
      p_addr = m_saddress;
    end
  end

  // builds the expected bus trace and result for one job, then hands the job over
  task automatic start_job(input logic [23:0] a1, input logic [23:0] a2, input int rdy,
                           input logic b0, input logic [31:0] w, input logic [31:0] l);
    bit ok;
    int polls;
    cfg_rdy = rdy; cfg_b0 = b0; cfg_w = w; cfg_l = l; stat_n = 0;
    trace.delete();
    exp_trace.delete();
    ok    = (rdy != 0) && (rdy <= PMAX);
    polls = ok ? rdy : PMAX;
    exp_trace.push_back(mk(1'b1, A_A1, {8'h00, a1}));
    exp_trace.push_back(mk(1'b1, A_A2, {8'h00, a2}));
    exp_trace.push_back(mk(1'b1, A_C, 32'h0));
    for (int i = 0; i < polls; i++) exp_trace.push_back(mk(1'b0, A_C, 32'h0));
    if (ok) begin
      exp_trace.push_back(mk(1'b0, A_W, 32'h0));
      exp_trace.push_back(mk(1'b0, A_L, 32'h0));
    end
    e_w    = ok ? w : 32'h0;
    e_ones = ok ? l[23:0] : 24'h0;
    e_ovf  = ok ? ~b0 : 1'b0;
    e_to   = !ok;
    @(negedge clk);
    chk("idle_ready", job_ready, 1);
    job_a1 = a1; job_a2 = a2; job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    chk("accept", job_ready, 0);
  endtask

  // waits for the result, optionally stalls, accepts it and checks the bus trace
  task automatic finish_job(input int hold);
    bit seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1;
    end
    chk("res_valid_seen", seen, 1);
    for (int i = 0; i < hold; i++) begin
      job_valid = 1'b1; job_a1 = 24'h00DEAD; job_a2 = 24'h00BEEF; res_ready = 1'b0;
      @(negedge clk);
      chk("bp_job_ready", job_ready, 0);
      chk("bp_res_valid", res_valid, 1);
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    last_w = res_w; last_ones = res_ones; last_ovf = res_ovf; last_to = res_timeout;
    @(posedge clk);
    exp_cnt++;
    @(negedge clk);
    res_ready = 1'b0;
    chk("ready_after_accept", job_ready, 1);
    chk("valid_drop", res_valid, 0);
    chk("trace_len", trace.size(), exp_trace.size());
    for (int i = 0; i < trace.size() && i < exp_trace.size(); i++)
      chk("trace_txn", trace[i], exp_trace[i]);
  endtask

  function automatic int count_rd(input logic [15:0] addr);
    int n = 0;
    foreach (trace[i]) if (!trace[i].wr && trace[i].addr == addr) n++;
    return n;
  endfunction

  initial begin
    bit found;
    n_reset = 1'b1; job_valid = 1'b0; res_ready = 1'b0;
    job_a1 = 24'h0; job_a2 = 24'h0; m_sdata_rd = 32'h0; exp_cnt = 16'h0;
    sl_prev = 1'b0; cfg_rdy = 0; cfg_b0 = 1'b0; cfg_w = 32'h0; cfg_l = 32'h0; stat_n = 0;
    #1 n_reset = 1'b0;
    #20;
    chk("rst_job_ready", job_ready, 1);
    chk("rst_outputs", {res_valid, m_swr, m_srd, res_ovf, res_timeout}, 5'b0);
    chk("rst_bus", {m_saddress, m_sdata_wr}, 48'h0);
    chk("rst_count", job_count, 0);
    @(negedge clk);
    n_reset = 1'b1;

    // basic job: ready on third poll
    start_job(24'd3, 24'd5, 3, 1'b1, 32'd15, 32'd4);
    finish_job(0);
    chk("basic_w", last_w, 32'd15);
    chk("basic_ones_ovf_to", {last_ones, last_ovf, last_to}, {24'd4, 2'b00});
    chk("basic_polls", count_rd(A_C), 3);
    chk("basic_count", job_count, 1);

    // overflow job, res_ready raised before the result exists
    res_ready = 1'b1;
    start_job(24'hFFFFFF, 24'hFFFFFF, 1, 1'b0, 32'hFE000001, 32'd8);
    finish_job(0);
    chk("ovf_w", last_w, 32'hFE000001);
    chk("ovf_ones_ovf", {last_ones, last_ovf}, {24'd8, 1'b1});

    // timeout: ready never reported
    start_job(24'h123456, 24'h000ABC, 0, 1'b1, 32'h11111111, 32'h22);
    finish_job(0);
    chk("to_polls", count_rd(A_C), 4);
    chk("to_no_wl", count_rd(A_W) + count_rd(A_L), 0);
    chk("to_flags", {last_w, last_to}, {32'h0, 1'b1});
    chk("to_count", job_count, 3);

    // backpressure with a competing job offered during the stall; junk in L upper bits
    start_job(24'h000100, 24'h000200, 2, 1'b1, 32'h00020000, 32'hFF000002);
    finish_job(10);
    chk("bp_ones", last_ones, 24'd2);
    chk("bp_count", job_count, 4);

    // reset while the operand-2 write strobe is high
    start_job(24'h000011, 24'h000022, 1, 1'b1, 32'h242, 32'h2);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (m_swr && m_saddress == A_A2) found = 1;
    end
    chk("swr_a2_seen", found, 1);
    #2 n_reset = 1'b0;
    exp_cnt = 16'h0;
    #1;
    chk("rst_mid_swr", m_swr, 0);
    chk("rst_mid_count", job_count, 0);
    chk("rst_mid_ready", job_ready, 1);
    chk("rst_mid_addr", m_saddress, 0);
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", job_ready, 1);

    // clean job after reset starts again from the operand-1 write
    start_job(24'd7, 24'd9, 1, 1'b1, 32'd63, 32'd6);
    finish_job(0);
    chk("clean_w_ones", {last_w, last_ones}, {32'd63, 24'd6});
    chk("clean_count", job_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_mult_initiator.md
Name: gpio_mult_initiator

Overview:
- Bus-master sequencer for the emulated GPIO multiplier peripheral; sits on the host side of the saddress/srd/swr/sdata bus.
- Accepts a job (two 24-bit operands) over a valid/ready handshake and writes the operands and the start command.
- Polls the status register until the peripheral reports ready, reads the product word and the ones count, then returns one result record.
- Counts completed jobs.

Parameters:
- ADDR_A1, 16'h037F: operand 1 register address.
- ADDR_A2, 16'h0388: operand 2 register address.
- ADDR_W, 16'h0390: product (low 32 bits) register address.
- ADDR_L, 16'h0398: ones-count register address.
- ADDR_CTRL, 16'h03A0: start (write) / status B (read) register address.
- SETUP_CYC, 1: cycles address/data are driven before the strobe rises (>=1).
- STB_CYC, 2: cycles a strobe is held high (>=1).
- START_WAIT, 4: idle cycles after the start write before the first status poll.
- POLL_MAX, 64: status reads before giving up with a timeout (>=1).

Ports:
- clk  in  1  clock.
- n_reset  in  1  reset; asynchronous, active-low.
- job_valid  in  1  job offered.
- job_ready  out  1  initiator can take a job.
- job_a1  in  24  operand 1.
- job_a2  in  24  operand 2.
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accepts result.
- res_w  out  32  product low word.
- res_ones  out  24  ones count.
- res_ovf  out  1  product exceeded 32 bits (status bit0 was 0).
- res_timeout  out  1  peripheral never reported ready.
- m_saddress  out  16  bus address.
- m_swr  out  1  write strobe.
- m_srd  out  1  read strobe.
- m_sdata_wr  out  32  write data to peripheral.
- m_sdata_rd  in  32  read data from peripheral.
- job_count  out  16  completed jobs (timeouts included), wraps at 16'hFFFF->0.

Behaviour:
- Reset (async, immediate):
  - All outputs 0, except job_ready=1.
  - Strobes drop in the same instant, even mid-transaction.
  - FSM returns to IDLE; latched operands are discarded.
- Bus transaction (sub-module) for every access:
  - SETUP: address and write data driven, strobes low, for SETUP_CYC cycles.
  - STROBE: the selected strobe is high for STB_CYC cycles; m_sdata_rd is captured on the last STROBE cycle.
  - HOLD: 1 cycle with strobe low and address/data held.
  - Between transactions: m_saddress=0, m_sdata_wr=0.
  - Only one strobe is ever high; m_swr and m_srd are never both 1.
- FSM states:
  - IDLE: job_ready=1. On job_valid&job_ready, latch operands, job_ready->0, go to WR_A1.
  - WR_A1: write {8'h0,a1} to ADDR_A1, go to WR_A2.
  - WR_A2: write {8'h0,a2} to ADDR_A2, go to WR_GO.
  - WR_GO: write 32'h0 to ADDR_CTRL (starts the peripheral), clear poll counter, go to WAIT.
  - WAIT: count START_WAIT cycles, then go to RD_STAT.
  - RD_STAT: read ADDR_CTRL and increment the poll counter.
    - If bit1==1: record ovf=~bit0, go to RD_W.
    - Else if poll counter==POLL_MAX: set timeout, res_w=0, res_ones=0, res_ovf=0, go to RESP.
    - Else: repeat RD_STAT back-to-back.
  - RD_W: read ADDR_W into res_w, go to RD_L.
  - RD_L: read ADDR_L; res_ones=rd[23:0], go to RESP.
  - RESP: res_valid=1.
    - Outputs are stable until res_valid&res_ready.
    - On accept: job_count+1, res_valid->0, return to IDLE; job_ready is 1 in the cycle after the accept.
- Latency and throughput:
  - One job in flight only; no overlap of jobs.
  - Minimum latency from job accept to res_valid is 5 transactions plus START_WAIT plus 1 cycle.
- Boundary conditions:
  - job_valid is ignored outside IDLE.
  - res_ready asserted early (before res_valid) has no effect.
  - Upper bits m_sdata_rd[31:2] of a status read are ignored.

Decomposition:
- Shared package gpio_mult_pkg:
  - Address localparams, matching the parameter defaults.
  - FSM state enum.
  - Status bit indices: READY_BIT=1, VALID_BIT=0.
- One sub-module gpio_bus_xfer:
  - Inputs: start, rnw, addr, wdata.
  - Outputs: done pulse, rdata, and the strobe/address/data pins.
  - Implements SETUP/STROBE/HOLD with its own cycle counter.

Test Plan:
- Basic job: a1=3, a2=5; slave model reports ready after 3 polls, W=15, L=4 -> writes in order 0x37F/0x000003, 0x388/0x000005, 0x3A0/0x0; 3 reads of 0x3A0, then 0x390, then 0x398; res_w=15, res_ones=4, res_ovf=0, job_count=1.
- Overflow: a1=a2=24'hFFFFFF; slave status=2'b10, W=32'hFE000001, L=8 -> res_w=32'hFE000001, res_ones=8, res_ovf=1.
- Timeout: POLL_MAX=4; status bit1 stuck at 0 -> exactly 4 reads of 0x3A0, no read of 0x390 or 0x398, res_timeout=1, res_w=0, job_count increments.
- Strobe timing: SETUP_CYC=1, STB_CYC=2 -> every swr/srd pulse is high exactly 2 cycles, address is stable from 1 cycle before the rise to 1 cycle after the fall, and srd/swr are never both high.
- Backpressure: hold res_ready=0 for 10 cycles -> res_* stable, job_ready=0, and a second job_valid is not accepted; then res_ready=1 -> accepted, job_ready=1 in the next cycle.
- Reset mid-operation: assert n_reset=0 while m_swr is high during WR_A2 -> m_swr=0 immediately, job_count=0, job_ready=1 after release; the next job runs cleanly from WR_A1.
